// File: rtl/matrix_pcpi_loader.sv
// Purpose: turns a pin-level byte stream into custom-0 PCPI instructions for the 3x3 matrix coprocessor.
// Latency: pcpi_valid rises the cycle after the final command byte; result/status one cycle after pcpi_ready.
// Backpressure: in_ready drops while an instruction is outstanding; byte states wait indefinitely on in_valid.
module matrix_pcpi_loader #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic [31:0] res_data,
    output logic        res_valid,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_addr
);

    localparam logic [1:0] S_HDR   = 2'd0;
    localparam logic [1:0] S_VLO   = 2'd1;
    localparam logic [1:0] S_VHI   = 2'd2;
    localparam logic [1:0] S_ISSUE = 2'd3;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_WRITE    = 3'b000;
    localparam logic [2:0] F3_START    = 3'b111;
    localparam logic [2:0] F3_CLEAR    = 3'b101;
    localparam logic [4:0] FIRST_BAD   = 5'd28;

    logic [1:0]    state_q, state_d;
    logic [4:0]    addr_q, addr_d;
    logic [7:0]    vlo_q, vlo_d;
    logic [31:0]   insn_q, insn_d;
    logic          valid_q, valid_d;
    logic          in_ready_q, in_ready_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_addr_q, err_addr_d;
    logic          accept;

    assign accept = in_valid & in_ready_q;

    // Next-state: byte assembly, instruction issue, completion/timeout and sticky errors.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        vlo_d         = vlo_q;
        insn_d        = insn_q;
        cnt_d         = cnt_q;
        res_data_d    = res_data_q;
        res_valid_d   = 1'b0;
        err_timeout_d = err_timeout_q;
        err_addr_d    = err_addr_q;

        case (state_q)
            S_HDR: begin
                if (accept) begin
                    case (in_data[7:6])
                        2'b00: begin
                            addr_d  = in_data[4:0];
                            state_d = S_VLO;
                        end
                        2'b01: begin
                            insn_d  = {17'd0, F3_START, 5'd0, OPC_CUSTOM0};
                            state_d = S_ISSUE;
                        end
                        2'b10: begin
                            insn_d  = {17'd0, F3_CLEAR, 5'd0, OPC_CUSTOM0};
                            state_d = S_ISSUE;
                        end
                        default: ; // reserved opcode: byte swallowed, nothing issued
                    endcase
                end
            end
            S_VLO: begin
                if (accept) begin
                    vlo_d   = in_data;
                    state_d = S_VHI;
                end
            end
            S_VHI: begin
                if (accept) begin
                    if (addr_q >= FIRST_BAD) begin
                        // Payload still drained so the stream stays framed.
                        err_addr_d = 1'b1;
                        state_d    = S_HDR;
                    end else begin
                        insn_d  = {1'b0, in_data, vlo_q, F3_WRITE, addr_q, OPC_CUSTOM0};
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                if (pcpi_ready) begin
                    state_d = S_HDR;
                    if (insn_q[14:12] == F3_START && pcpi_wr) begin
                        res_data_d  = pcpi_rd;
                        res_valid_d = 1'b1;
                    end
                end else if (!pcpi_wait) begin
                    if (cnt_q == TW'(TIMEOUT - 1)) begin
                        err_timeout_d = 1'b1;
                        state_d       = S_HDR;
                    end else begin
                        cnt_d = cnt_q + TW'(1);
                    end
                end
            end
        endcase

        if (state_d == S_ISSUE && state_q != S_ISSUE) begin
            cnt_d = '0;
        end

        valid_d    = (state_d == S_ISSUE);
        in_ready_d = (state_d != S_ISSUE);
    end

    // State and output registers; reset parks everything idle with in_ready low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_HDR;
            addr_q        <= '0;
            vlo_q         <= '0;
            insn_q        <= '0;
            valid_q       <= 1'b0;
            in_ready_q    <= 1'b0;
            cnt_q         <= '0;
            res_data_q    <= '0;
            res_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_addr_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            vlo_q         <= vlo_d;
            insn_q        <= insn_d;
            valid_q       <= valid_d;
            in_ready_q    <= in_ready_d;
            cnt_q         <= cnt_d;
            res_data_q    <= res_data_d;
            res_valid_q   <= res_valid_d;
            err_timeout_q <= err_timeout_d;
            err_addr_q    <= err_addr_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign pcpi_valid  = valid_q;
    assign pcpi_insn   = insn_q;
    assign res_data    = res_data_q;
    assign res_valid   = res_valid_q;
    assign busy        = (state_q != S_HDR);
    assign err_timeout = err_timeout_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_matrix_pcpi_loader.sv
// Purpose: directed plus randomized command stream against a behavioural model of the loader.
// Latency: checks issue one cycle after the last byte and completion one cycle after pcpi_ready.
// Backpressure: byte sender waits (bounded) on in_ready and inserts random in_valid gaps.
module tb_matrix_pcpi_loader;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = 32'd0;
    logic        pcpi_wait = 1'b0;
    logic        pcpi_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_valid;
    logic        busy;
    logic        err_timeout;
    logic        err_addr;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_res = 32'd0;
    logic        m_errt = 1'b0;
    logic        m_erra = 1'b0;

    matrix_pcpi_loader #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
        .clk(clk), .resetn(resetn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_wr(pcpi_wr),
        .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .res_data(res_data), .res_valid(res_valid), .busy(busy),
        .err_timeout(err_timeout), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk1("in_ready_wait", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Drive the coprocessor side for one outstanding instruction and check the outcome.
    task automatic do_issue(input logic [31:0] expv, input bit is_start, input int stall,
                            input int wmode, input logic wr, input logic [31:0] rd);
        int  idle;
        bit  timed_out;
        bit  expect_res;
        idle = 0;
        timed_out = 0;
        chk1("valid_rise", pcpi_valid, 1'b1);
        chk("insn", pcpi_insn, expv);
        chk1("busy_issue", busy, 1'b1);
        chk1("in_ready_issue", in_ready, 1'b0);
        for (int c = 0; c < stall && !timed_out; c++) begin
            pcpi_ready = 1'b0;
            pcpi_wait  = (wmode == 0) ? 1'b0 : (wmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            pcpi_wr    = 1'($urandom);
            pcpi_rd    = $urandom;
            if (!pcpi_wait) idle++;
            @(negedge clk);
            if (idle == TIMEOUT) timed_out = 1;
            chk1("valid_hold", pcpi_valid, !timed_out);
        end
        pcpi_wait = 1'b0;
        if (!timed_out) begin
            pcpi_ready = 1'b1;
            pcpi_wr    = wr;
            pcpi_rd    = rd;
            @(negedge clk);
            pcpi_ready = 1'b0;
            pcpi_wr    = 1'b0;
            expect_res = is_start && wr;
            if (expect_res) m_res = rd;
            chk1("valid_fall", pcpi_valid, 1'b0);
            chk("insn_held", pcpi_insn, expv);
            chk1("res_valid", res_valid, expect_res);
        end else begin
            m_errt = 1'b1;
            chk1("res_valid_to", res_valid, 1'b0);
        end
        chk("res_data", res_data, m_res);
        chk1("err_timeout", err_timeout, m_errt);
        chk1("in_ready_back", in_ready, 1'b1);
        chk1("busy_back", busy, 1'b0);
        @(negedge clk);
        chk1("res_valid_pulse", res_valid, 1'b0);
    endtask

    task automatic send_cmd(input int op, input int addr, input logic [15:0] val, input int stall,
                            input int wmode, input logic wr, input logic [31:0] rd);
        logic [7:0]  hdr;
        logic [31:0] expv;
        hdr = {op[1:0], 1'($urandom), addr[4:0]};
        idle_gap();
        send_byte(hdr);
        if (op == 3) begin
            chk1("drop_busy", busy, 1'b0);
            chk1("drop_valid", pcpi_valid, 1'b0);
            return;
        end
        if (op == 0) begin
            chk1("busy_vlo", busy, 1'b1);
            idle_gap();
            send_byte(val[7:0]);
            idle_gap();
            send_byte(val[15:8]);
            if (addr >= 28) begin
                m_erra = 1'b1;
                chk1("badaddr_valid", pcpi_valid, 1'b0);
                chk1("badaddr_busy", busy, 1'b0);
                chk1("err_addr", err_addr, m_erra);
                return;
            end
            expv = 32'h0B + (32'(addr) << 7) + (32'(val) << 15);
        end else begin
            expv = 32'h0B + (32'((op == 1) ? 7 : 5) << 12);
        end
        do_issue(expv, op == 1, stall, wmode, wr, rd);
        chk1("err_addr_keep", err_addr, m_erra);
    endtask

    initial begin
        // Reset values
        #12;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_valid", pcpi_valid, 1'b0);
        chk("rst_insn", pcpi_insn, 32'd0);
        chk("rst_res", res_data, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        #1 chk1("rel_in_ready0", in_ready, 1'b0);
        @(negedge clk);
        chk1("rel_in_ready1", in_ready, 1'b1);

        // Element write, immediate completion
        send_cmd(0, 0, 16'h1234, 0, 0, 1'b1, 32'hDEAD_BEEF);
        chk("tp_insn_write", pcpi_insn, 32'h091A000B);
        // Negative threshold at last legal address, then clear
        send_cmd(0, 27, 16'hFFBA, 3, 2, 1'b0, 32'd0);
        chk("tp_insn_thr", pcpi_insn, 32'h7FDD0D8B);
        send_cmd(2, 0, 16'd0, 2, 0, 1'b1, 32'h1111_2222);
        chk("tp_insn_clear", pcpi_insn, 32'h0000500B);
        // Start held off by pcpi_wait, then returns a result
        send_cmd(1, 0, 16'd0, 8, 1, 1'b1, 32'h0000_01FF);
        chk("tp_insn_start", pcpi_insn, 32'h0000700B);
        chk("tp_res", res_data, 32'h0000_01FF);
        // Long pcpi_wait stretch never times out
        send_cmd(1, 0, 16'd0, 40, 1, 1'b0, 32'h5);
        // Ready on the cycle the count would reach TIMEOUT is a completion
        send_cmd(1, 0, 16'd0, TIMEOUT - 1, 0, 1'b1, 32'hCAFE_0001);
        chk1("edge_no_timeout", err_timeout, 1'b0);
        // Real timeout, then a normal command
        send_cmd(1, 0, 16'd0, TIMEOUT + 4, 0, 1'b1, 32'h0);
        chk1("timeout_set", err_timeout, 1'b1);
        send_cmd(0, 5, 16'h00AA, 1, 0, 1'b0, 32'h0);
        // Illegal address, reserved opcode
        send_cmd(0, 29, 16'h0001, 0, 0, 1'b0, 32'h0);
        chk1("err_addr_set", err_addr, 1'b1);
        send_cmd(3, 5, 16'd0, 0, 0, 1'b0, 32'h0);
        send_cmd(0, 28, 16'hFFFF, 0, 0, 1'b0, 32'h0);
        send_cmd(0, 3, 16'h8001, 0, 0, 1'b0, 32'h0);

        // Randomized command mix
        for (int i = 0; i < 60; i++) begin
            send_cmd($urandom_range(0, 3), $urandom_range(0, 31), 16'($urandom),
                     $urandom_range(0, 22), 2, 1'($urandom), $urandom);
        end

        // Asynchronous reset while an instruction is outstanding
        send_cmd(0, 30, 16'h0, 0, 0, 1'b0, 32'h0);
        send_cmd(1, 0, 16'd0, TIMEOUT + 1, 0, 1'b0, 32'h0);
        idle_gap();
        send_byte(8'h40);
        chk1("pre_rst_valid", pcpi_valid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk1("arst_valid", pcpi_valid, 1'b0);
        chk("arst_insn", pcpi_insn, 32'd0);
        chk1("arst_in_ready", in_ready, 1'b0);
        chk("arst_res", res_data, 32'd0);
        chk1("arst_res_valid", res_valid, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_errt", err_timeout, 1'b0);
        chk1("arst_erra", err_addr, 1'b0);
        m_res = 32'd0;
        m_errt = 1'b0;
        m_erra = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1 chk1("rel2_in_ready0", in_ready, 1'b0);
        @(negedge clk);
        chk1("rel2_in_ready1", in_ready, 1'b1);
        send_cmd(1, 0, 16'd0, 2, 2, 1'b1, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
